// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: FP register file with two write-back ports, read bypass and pending-write scoreboard
module fp_regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int LOCK_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rd_addr0,
    input  logic [AW-1:0]     rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              src_busy0,
    output logic              src_busy1,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREGS-1:0]  busy_vec,
    output logic [AW:0]       pend_cnt,
    output logic              err_dbl
);
    localparam bit LOCK = LOCK_R0 != 0;
    localparam bit BYP  = BYPASS != 0;

    logic [DATA_W-1:0] regs [NREGS];
    logic              w0_ok, w1_ok, iss_ok, dbl;
    logic [NREGS-1:0]  set_vec, clr_vec, busy_nxt;
    logic [AW:0]       cnt_nxt;

    assign w0_ok  = wr0_en && !(LOCK && wr0_addr == '0);
    assign w1_ok  = wr1_en && !(LOCK && wr1_addr == '0);
    assign iss_ok = iss_valid && !(LOCK && iss_rd == '0);

    // read ports: wr1 forwarding beats wr0 forwarding beats stored value
    always_comb begin
        rd_data0 = (BYP && w1_ok && wr1_addr == rd_addr0) ? wr1_data :
                   (BYP && w0_ok && wr0_addr == rd_addr0) ? wr0_data : regs[rd_addr0];
        rd_data1 = (BYP && w1_ok && wr1_addr == rd_addr1) ? wr1_data :
                   (BYP && w0_ok && wr0_addr == rd_addr1) ? wr0_data : regs[rd_addr1];
    end

    assign src_busy0 = busy_vec[rd_addr0];
    assign src_busy1 = busy_vec[rd_addr1];

    // register array; wr1 is applied last so it wins on an address collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (w0_ok) regs[wr0_addr] <= wr0_data;
            if (w1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    // scoreboard next state: issue set overrides write-back clear, count follows the new vector
    always_comb begin
        set_vec         = '0;
        clr_vec         = '0;
        set_vec[iss_rd] = iss_ok;
        clr_vec[wr1_addr] = wr1_en;
        busy_nxt        = (busy_vec & ~clr_vec) | set_vec;
        cnt_nxt         = '0;
        for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    assign dbl = iss_ok && busy_vec[iss_rd] && !(wr1_en && wr1_addr == iss_rd);

    // scoreboard state and sticky double-issue flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_vec <= '0;
            pend_cnt <= '0;
            err_dbl  <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            pend_cnt <= cnt_nxt;
            err_dbl  <= err_dbl | dbl;
        end
    end
endmodule
